// File: rtl/mvau_weight_fetch.sv
// Weight-fetch sequencer: sweeps the weight memory read address, absorbs the
// 1-cycle read latency and streams weight words to the PE over valid/ready.
module mvau_weight_fetch #(
    parameter int unsigned SIMD         = 2,
    parameter int unsigned TW           = 1,
    parameter int unsigned WMEM_DEPTH   = 4,
    parameter int unsigned WMEM_ADDR_BW = 4
) (
    input  logic                    aclk,
    input  logic                    areset,
    input  logic                    fetch_en,
    output logic [WMEM_ADDR_BW-1:0] wmem_addr,
    input  logic [SIMD*TW-1:0]      wmem_in,
    output logic                    w_valid,
    input  logic                    w_ready,
    output logic [SIMD*TW-1:0]      w_data,
    output logic                    w_last
);

    localparam int unsigned DW = SIMD * TW;
    localparam logic [WMEM_ADDR_BW-1:0] ADDR_LAST = WMEM_ADDR_BW'(WMEM_DEPTH - 1);

    logic [WMEM_ADDR_BW-1:0] addr_cnt;
    logic                    pend;
    logic                    pend_last;
    logic [DW-1:0]           head_data;
    logic [DW-1:0]           tail_data;
    logic                    head_last;
    logic                    tail_last;
    logic [1:0]              occ;

    logic       pop;
    logic       issue;
    logic       at_last;
    logic [2:0] fill;

    // A read is issued only if its word is guaranteed a FIFO slot, counting
    // the read still in flight and any word leaving this cycle.
    always_comb begin
        pop     = (occ != 2'd0) && w_ready;
        fill    = 3'(occ) + 3'(pend);
        issue   = fetch_en && (fill < (3'd2 + 3'(pop)));
        at_last = (addr_cnt == ADDR_LAST);
    end

    always_ff @(posedge aclk) begin
        if (areset) begin
            addr_cnt  <= '0;
            pend      <= 1'b0;
            pend_last <= 1'b0;
        end else if (issue) begin
            pend      <= 1'b1;
            pend_last <= at_last;
            addr_cnt  <= at_last ? '0 : addr_cnt + WMEM_ADDR_BW'(1);
        end else begin
            pend      <= 1'b0;
        end
    end

    always_ff @(posedge aclk) begin
        if (areset) begin
            occ       <= '0;
            head_data <= '0;
            head_last <= 1'b0;
            tail_data <= '0;
            tail_last <= 1'b0;
        end else begin
            case ({pend, pop})
                2'b10: begin
                    if (occ == 2'd0) begin
                        head_data <= wmem_in;
                        head_last <= pend_last;
                    end else begin
                        tail_data <= wmem_in;
                        tail_last <= pend_last;
                    end
                    occ <= occ + 2'd1;
                end
                2'b01: begin
                    head_data <= tail_data;
                    head_last <= tail_last;
                    occ       <= occ - 2'd1;
                end
                2'b11: begin
                    if (occ == 2'd1) begin
                        head_data <= wmem_in;
                        head_last <= pend_last;
                    end else begin
                        head_data <= tail_data;
                        head_last <= tail_last;
                        tail_data <= wmem_in;
                        tail_last <= pend_last;
                    end
                end
                default: ;
            endcase
        end
    end

    assign wmem_addr = addr_cnt;
    assign w_valid   = (occ != 2'd0);
    assign w_data    = head_data;
    assign w_last    = head_last;

endmodule

// File: tb/tb_mvau_weight_fetch.sv
// Directed bench for mvau_weight_fetch with a 4-word registered weight memory
// holding data equal to its address.
module tb_mvau_weight_fetch;

    logic       aclk;
    logic       areset;
    logic       fetch_en;
    logic [3:0] wmem_addr;
    logic [1:0] wmem_in;
    logic       w_valid;
    logic       w_ready;
    logic [1:0] w_data;
    logic       w_last;

    logic [1:0] mem [4];

    int n_vec;
    int n_err;
    int exp_idx;
    int acc;
    int n_last;

    mvau_weight_fetch #(
        .SIMD         (2),
        .TW           (1),
        .WMEM_DEPTH   (4),
        .WMEM_ADDR_BW (4)
    ) dut (
        .aclk      (aclk),
        .areset    (areset),
        .fetch_en  (fetch_en),
        .wmem_addr (wmem_addr),
        .wmem_in   (wmem_in),
        .w_valid   (w_valid),
        .w_ready   (w_ready),
        .w_data    (w_data),
        .w_last    (w_last)
    );

    initial aclk = 1'b0;
    always #5 aclk = ~aclk;

    always @(posedge aclk) wmem_in <= mem[wmem_addr[1:0]];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic cyc();
        @(posedge aclk);
        #1;
    endtask

    // Expected word k carries data k mod 4 and last on every fourth word.
    task automatic score();
        if (w_valid && w_ready) begin
            check("seq_data", 32'(w_data), 32'(exp_idx % 4));
            check("seq_last", 32'(w_last), 32'((exp_idx % 4) == 3));
            if (w_last) n_last++;
            exp_idx++;
            acc++;
        end
    endtask

    initial begin
        n_vec = 0; n_err = 0; exp_idx = 0; acc = 0; n_last = 0;
        for (int i = 0; i < 4; i++) mem[i] = 2'(i);
        areset   = 1'b1;
        fetch_en = 1'b1;
        w_ready  = 1'b1;

        repeat (3) begin
            cyc();
            check("rst_valid", 32'(w_valid), 0);
            check("rst_data",  32'(w_data),  0);
            check("rst_last",  32'(w_last),  0);
            check("rst_addr",  32'(wmem_addr), 0);
        end

        // Streaming: cycle 0 is the first cycle out of reset.
        areset = 1'b0;
        check("c0_valid", 32'(w_valid), 0);
        check("c0_addr",  32'(wmem_addr), 0);
        cyc();
        check("c1_valid", 32'(w_valid), 0);
        check("c1_addr",  32'(wmem_addr), 1);
        cyc();
        for (int n = 2; n < 14; n++) begin
            check("stream_valid", 32'(w_valid), 1);
            score();
            cyc();
        end

        // Backpressure for cycles 14..18: head holds word 12 (data 0).
        w_ready = 1'b0;
        check("bp_valid", 32'(w_valid), 1);
        check("bp_data",  32'(w_data), 0);
        check("bp_addr",  32'(wmem_addr), 2);
        repeat (4) begin
            cyc();
            check("bp_valid", 32'(w_valid), 1);
            check("bp_data",  32'(w_data), 0);
            check("bp_last",  32'(w_last), 0);
            check("bp_addr",  32'(wmem_addr), 2);
        end
        cyc();
        w_ready = 1'b1;
        for (int n = 0; n < 8; n++) begin
            check("resume_valid", 32'(w_valid), 1);
            score();
            cyc();
        end
        check("resume_count", 32'(exp_idx), 20);

        // Random ready: 40 words starting at address 0.
        acc = 0;
        n_last = 0;
        for (int c = 0; c < 400 && acc < 40; c++) begin
            w_ready = 1'($urandom_range(0, 1));
            score();
            cyc();
        end
        check("rr_count", 32'(acc), 40);
        check("rr_lasts", 32'(n_last), 10);

        // Fill the buffer, then reset mid-run.
        w_ready = 1'b0;
        repeat (3) cyc();
        check("pre_rst_valid", 32'(w_valid), 1);
        areset = 1'b1;
        cyc();
        check("mrst_valid", 32'(w_valid), 0);
        check("mrst_data",  32'(w_data), 0);
        check("mrst_addr",  32'(wmem_addr), 0);

        // One-cycle fetch_en pulse after release.
        areset   = 1'b0;
        fetch_en = 1'b1;
        w_ready  = 1'b1;
        check("p0_valid", 32'(w_valid), 0);
        cyc();
        fetch_en = 1'b0;
        check("p1_valid", 32'(w_valid), 0);
        check("p1_addr",  32'(wmem_addr), 1);
        cyc();
        check("p2_valid", 32'(w_valid), 1);
        check("p2_data",  32'(w_data), 0);
        check("p2_last",  32'(w_last), 0);
        for (int n = 0; n < 4; n++) begin
            cyc();
            check("p_idle_valid", 32'(w_valid), 0);
            check("p_idle_addr",  32'(wmem_addr), 1);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
